mc_control_fsm: RTL and testbench

Multicycle control FSM for the MIPS-subset datapath. It sequences instruction fetch, decode, execute, memory and writeback, and drives every datapath select and write-enable, including the ALU operand selects and the ALU operation. It sits beside the datapath, takes `opcode`/`funct` from the instruction register and the ALU `zero` flag, and returns Moore-style control words.

---
 rtl/mc_control_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the MIPS-subset datapath. Sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and write enable
// as Moore-style control words.
module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       alu_out_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       trap,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        StReset   = 4'd0,
        StFetch   = 4'd1,
        StFetchWt = 4'd2,
        StDecode  = 4'd3,
        StExecR   = 4'd4,
        StWbR     = 4'd5,
        StExecI   = 4'd6,
        StWbI     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StMemAddr = 4'd10,
        StMemRead = 4'd11,
        StMemWait = 4'd12,
        StWbMem   = 4'd13,
        StMemWr   = 4'd14,
        StTrap    = 4'd15
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    state_e state_q, state_d;
    logic   funct_ok;

    // zero only feeds the datapath PC-write logic; the controller never looks at it.
    logic unused_zero;
    assign unused_zero = zero;

    assign state_out = state_q;

    // R-type funct codes the datapath can execute.
    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
            default:                           funct_ok = 1'b0;
        endcase
    end

    // State register; reset wins asynchronously so in-flight writes drop immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control-word decode.
    always_comb begin
        state_d       = state_q;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = AluAdd;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        alu_out_write = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        trap          = 1'b0;

        unique case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                alu_src_b = 2'b01;
                state_d   = StFetchWt;
            end
            StFetchWt: begin
                // Memory read data is valid now: latch IR and commit PC+4.
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                // Precompute branch target while registers are read.
                alu_src_b     = 2'b11;
                alu_out_write = 1'b1;
                a_write       = 1'b1;
                b_write       = 1'b1;
                case (opcode)
                    6'h00:        state_d = funct_ok ? StExecR : StTrap;
                    6'h08:        state_d = StExecI;
                    6'h04, 6'h05: state_d = StBranch;
                    6'h02:        state_d = StJump;
                    6'h23, 6'h2B: state_d = StMemAddr;
                    default:      state_d = StTrap;
                endcase
            end
            StExecR: begin
                alu_src_a     = 1'b1;
                alu_out_write = 1'b1;
                case (funct)
                    6'h22:   alu_op = AluSub;
                    6'h24:   alu_op = AluAnd;
                    6'h25:   alu_op = AluOr;
                    6'h2A:   alu_op = AluSlt;
                    default: alu_op = AluAdd;
                endcase
                state_d = StWbR;
            end
            StWbR: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StExecI: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_out_write = 1'b1;
                state_d       = StWbI;
            end
            StWbI: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                branch_ne     = (opcode == 6'h05);
                state_d       = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = StFetch;
            end
            StMemAddr: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_out_write = 1'b1;
                state_d       = (opcode == 6'h23) ? StMemRead : StMemWr;
            end
            StMemRead: begin
                i_or_d  = 1'b1;
                state_d = StMemWait;
            end
            StMemWait: begin
                i_or_d    = 1'b1;
                mdr_write = 1'b1;
                state_d   = StWbMem;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_d   = StFetch;
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StReset;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm: walks each instruction class
// through its state sequence and compares the full control word in every state.
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d, mem_write, ir_write, mdr_write, a_write, b_write;
    logic       alu_out_write, reg_write, reg_dst, mem_to_reg, trap;
    logic [3:0] state_out;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] op;
        logic       pcw;
        logic       pcwc;
        logic       bne;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       mdrw;
        logic       aw;
        logic       bw;
        logic       aluow;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic       trap;
    } ctl_t;

    ctl_t ctl_obs;

    mc_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .a_write       (a_write),
        .b_write       (b_write),
        .alu_out_write (alu_out_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .trap          (trap),
        .state_out     (state_out)
    );

    always_comb begin
        ctl_obs = '{src_a: alu_src_a, src_b: alu_src_b, op: alu_op, pcw: pc_write,
                    pcwc: pc_write_cond, bne: branch_ne, pcsrc: pc_source, iord: i_or_d,
                    memw: mem_write, irw: ir_write, mdrw: mdr_write, aw: a_write,
                    bw: b_write, aluow: alu_out_write, regw: reg_write, regdst: reg_dst,
                    m2r: mem_to_reg, trap: trap};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word each state should present, written from the state table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                     input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (st)
            4'd1: c.src_b = 2'b01;
            4'd2: begin c.src_b = 2'b01; c.irw = 1'b1; c.pcw = 1'b1; end
            4'd3: begin c.src_b = 2'b11; c.aluow = 1'b1; c.aw = 1'b1; c.bw = 1'b1; end
            4'd4: begin
                c.src_a = 1'b1;
                c.aluow = 1'b1;
                case (fn)
                    6'h22:   c.op = 3'b001;
                    6'h24:   c.op = 3'b010;
                    6'h25:   c.op = 3'b011;
                    6'h2A:   c.op = 3'b100;
                    default: c.op = 3'b000;
                endcase
            end
            4'd5:  begin c.regw = 1'b1; c.regdst = 1'b1; end
            4'd6:  begin c.src_a = 1'b1; c.src_b = 2'b10; c.aluow = 1'b1; end
            4'd7:  c.regw = 1'b1;
            4'd8:  begin
                c.src_a = 1'b1; c.op = 3'b001; c.pcwc = 1'b1; c.pcsrc = 2'b01;
                c.bne = (op == 6'h05);
            end
            4'd9:  begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            4'd10: begin c.src_a = 1'b1; c.src_b = 2'b10; c.aluow = 1'b1; end
            4'd11: c.iord = 1'b1;
            4'd12: begin c.iord = 1'b1; c.mdrw = 1'b1; end
            4'd13: begin c.regw = 1'b1; c.m2r = 1'b1; end
            4'd14: begin c.iord = 1'b1; c.memw = 1'b1; end
            4'd15: c.trap = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Advance to the next falling edge and check state and control word.
    task automatic step(input string tag, input logic [3:0] exp_st);
        zero = 1'($urandom);
        @(negedge clk);
        check({tag, "_state"}, 32'(state_out), 32'(exp_st));
        check({tag, "_ctl"}, 32'(ctl_obs), 32'(exp_ctl(exp_st, opcode, funct)));
    endtask

    // seq holds n expected states as nibbles, first state in the most significant one.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input int n, input logic [31:0] seq);
        opcode = op;
        funct  = fn;
        for (int k = 0; k < n; k++) begin
            step($sformatf("%s_%0d", tag, k), seq[4*(n-1-k) +: 4]);
        end
    endtask

    task automatic reset_mid(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, "_rst_state"}, 32'(state_out), 32'd0);
        check({tag, "_rst_ctl"}, 32'(ctl_obs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step({tag, "_restart"}, 4'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        opcode   = 6'h00;
        funct    = 6'h20;
        zero     = 1'b0;

        #3;
        check("por_state", 32'(state_out), 32'd0);
        check("por_ctl", 32'(ctl_obs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("boot", 4'd1);

        run("add",  6'h00, 6'h20, 5, 32'h23451);
        run("slt",  6'h00, 6'h2A, 5, 32'h23451);
        run("sub",  6'h00, 6'h22, 5, 32'h23451);
        run("or",   6'h00, 6'h25, 5, 32'h23451);
        run("lw",   6'h23, 6'h00, 7, 32'h23ABCD1);
        run("sw",   6'h2B, 6'h00, 5, 32'h23AE1);
        run("beq",  6'h04, 6'h00, 4, 32'h2381);
        run("bne",  6'h05, 6'h00, 4, 32'h2381);
        run("addi", 6'h08, 6'h00, 5, 32'h23671);
        run("j",    6'h02, 6'h00, 4, 32'h2391);

        // Illegal opcode: TRAP holds with all enables low until reset.
        run("ill", 6'h3F, 6'h00, 3, 32'h23F);
        for (int k = 0; k < 10; k++) step($sformatf("ill_hold%0d", k), 4'd15);
        reset_mid("ill");

        // R-type with an unsupported funct also traps.
        run("badfn", 6'h00, 6'h00, 3, 32'h23F);
        for (int k = 0; k < 10; k++) step($sformatf("badfn_hold%0d", k), 4'd15);
        reset_mid("badfn");

        // Reset during a store cancels mem_write within the cycle.
        run("swrst", 6'h2B, 6'h00, 4, 32'h23AE);
        check("swrst_memw_before", 32'(mem_write), 32'd1);
        reset_mid("swrst");
        run("after", 6'h00, 6'h24, 5, 32'h23451);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
